// File: rtl/dcdw_vec_module.sv
// Outer-product delta-weight generator: captures a[N_A] and delta[N_D], then streams
// a[i]*delta[j]*2^-LR_SHIFT (row-major, j fastest) over a valid/ready port.
module dcdw_vec_module #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 10,
  parameter int N_A      = 4,
  parameter int N_D      = 2,
  parameter int LR_SHIFT = 5,
  parameter int SAT_EN   = 1,
  localparam int RW = (N_A > 1) ? $clog2(N_A) : 1,
  localparam int CW = (N_D > 1) ? $clog2(N_D) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              i_step,
  input  logic                    i_start,
  input  logic [N_A*DATA_W-1:0]   i_a_vec,
  input  logic [N_D*DATA_W-1:0]   i_delta_vec,
  output logic                    o_busy,
  output logic                    o_dw_valid,
  input  logic                    i_dw_ready,
  output logic [DATA_W-1:0]       o_dw_data,
  output logic [RW-1:0]           o_dw_row,
  output logic [CW-1:0]           o_dw_col,
  output logic                    o_done
);

  localparam int PW = 2*DATA_W;
  localparam int SH = FRAC_W + LR_SHIFT;
  localparam logic signed [PW-1:0] MAXV = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT, S_DONE} state_t;

  state_t                          r_state, w_next;
  logic [N_A-1:0][DATA_W-1:0]      r_a;
  logic [N_D-1:0][DATA_W-1:0]      r_d;
  logic [RW-1:0]                   r_i;
  logic [CW-1:0]                   r_j;
  logic signed [PW-1:0]            r_prod;
  logic signed [PW-1:0]            w_pa, w_pd, w_shift;
  logic [DATA_W-1:0]               w_res, w_ai, w_dj;
  logic                            w_accept, w_hs, w_last;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_step != 4'd0);
  assign w_hs     = (r_state == S_OUT) && i_dw_ready;
  assign w_last   = (r_i == RW'(N_A-1)) && (r_j == CW'(N_D-1));

  // Sign-extend both operands to full product width so the multiply is exact.
  assign w_ai = r_a[r_i];
  assign w_dj = r_d[r_j];
  assign w_pa = {{DATA_W{w_ai[DATA_W-1]}}, w_ai};
  assign w_pd = {{DATA_W{w_dj[DATA_W-1]}}, w_dj};
  assign w_shift = r_prod >>> SH;

  generate
    if (SAT_EN != 0) begin : g_sat
      always_comb begin
        w_res = w_shift[DATA_W-1:0];
        if (w_shift > MAXV)      w_res = MAXV[DATA_W-1:0];
        else if (w_shift < MINV) w_res = MINV[DATA_W-1:0];
      end
    end else begin : g_wrap
      logic w_unused_hi;
      assign w_unused_hi = ^w_shift[PW-1:DATA_W];
      assign w_res = w_shift[DATA_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_MUL;
      S_MUL:  w_next = S_OUT;
      S_OUT:  if (w_hs) w_next = w_last ? S_DONE : S_MUL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_d    <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_prod <= '0;
    end else begin
      if (w_accept) begin
        r_a <= i_a_vec;
        r_d <= i_delta_vec;
        r_i <= '0;
        r_j <= '0;
      end
      if (r_state == S_MUL) r_prod <= w_pa * w_pd;
      if (w_hs && !w_last) begin
        if (r_j == CW'(N_D-1)) begin
          r_j <= '0;
          r_i <= r_i + RW'(1);
        end else begin
          r_j <= r_j + CW'(1);
        end
      end
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_dw_valid = (r_state == S_OUT);
  assign o_dw_data  = o_dw_valid ? w_res : '0;
  assign o_dw_row   = r_i;
  assign o_dw_col   = r_j;

endmodule

// File: tb/tb_dcdw_vec_module.sv
// Directed bench for dcdw_vec_module: a saturating and a wrapping instance share stimulus.
module tb_dcdw_vec_module;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  step;
  logic        start;
  logic [63:0] a_vec;
  logic [31:0] d_vec;
  logic        ready;
  logic        busy, valid, done, busy1, valid1, done1;
  logic [15:0] data, data1;
  logic [1:0]  row, row1;
  logic [0:0]  col, col1;
  logic [15:0] exp_d [8];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcdw_vec_module u_sat (
    .clk(clk), .rst_n(rst_n), .i_step(step), .i_start(start), .i_a_vec(a_vec),
    .i_delta_vec(d_vec), .o_busy(busy), .o_dw_valid(valid), .i_dw_ready(ready),
    .o_dw_data(data), .o_dw_row(row), .o_dw_col(col), .o_done(done));

  dcdw_vec_module #(.SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_step(step), .i_start(start), .i_a_vec(a_vec),
    .i_delta_vec(d_vec), .o_busy(busy1), .o_dw_valid(valid1), .i_dw_ready(ready),
    .o_dw_data(data1), .o_dw_row(row1), .o_dw_col(col1), .o_done(done1));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept at edge k (c=0), then return at the negedge after edge k+1 (c=1).
  task automatic kick();
    step  = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_c0_valid", {31'd0, valid}, 32'd0);
    chk("lat_c0_busy", {31'd0, busy}, 32'd1);
    tick();
  endtask

  task automatic drain(input int exp_done_c, input bit stall, input bit poke_done);
    int got, dones, dc;
    bit stalled;
    logic [15:0] hd;
    got = 0; dones = 0; dc = -1; stalled = 1'b0;
    for (int c = 1; c < 45; c++) begin
      if (stall && !stalled && got == 2 && valid) begin
        stalled = 1'b1;
        hd = data;
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          // Start mid-stream and input/step changes must not disturb the captured job.
          start = 1'b1; step = 4'd3; a_vec = 64'h1234_5678_9ABC_DEF0;
          tick(); c++;
          start = 1'b0; step = 4'd0;
          chk("stall_valid", {31'd0, valid}, 32'd1);
          chk("stall_data", {16'd0, data}, {16'd0, hd});
          chk("stall_row", {30'd0, row}, 32'd1);
          chk("stall_col", {31'd0, col}, 32'd0);
        end
        ready = 1'b1;
      end
      if (valid && ready) begin
        if (got < 8) begin
          chk("dw_data", {16'd0, data}, {16'd0, exp_d[got]});
          chk("dw_row", {30'd0, row}, got / 2);
          chk("dw_col", {31'd0, col}, got % 2);
        end
        got++;
      end
      if (done) begin
        dones++;
        dc = c;
        if (poke_done) begin start = 1'b1; step = 4'd1; end
      end
      tick();
      start = 1'b0;
    end
    chk("elem_count", got, 8);
    chk("done_count", dones, 1);
    chk("done_cycle", dc, exp_done_c);
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic set_t2();
    a_vec = {16'h0000, 16'hFC00, 16'h0800, 16'h0400};
    d_vec = {16'hF800, 16'h0400};
    exp_d = '{16'h0020, 16'hFFC0, 16'h0040, 16'hFF80, 16'hFFE0, 16'h0040, 16'h0000, 16'h0000};
  endtask

  initial begin
    rst_n = 1'b0; step = 4'd0; start = 1'b0; a_vec = '0; d_vec = '0; ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: 4.0*4.0/32 = 0.5
    a_vec = 64'h0000_0000_0000_1000; d_vec = 32'h0000_1000;
    exp_d = '{16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    kick();
    chk("t1_first_valid", {31'd0, valid}, 32'd1);
    drain(16, 1'b0, 1'b0);

    // T2: full outer product, start poked on the done cycle
    set_t2();
    kick();
    drain(16, 1'b0, 1'b1);
    tick();
    chk("t2_done_start_ign", {31'd0, busy}, 32'd0);

    // T3: -32*-32 overflows
    a_vec = 64'h0000_0000_0000_8000; d_vec = 32'h0000_8000;
    exp_d = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    kick();
    chk("t3_wrap_data", {16'd0, data1}, 32'h0000_8000);
    drain(16, 1'b0, 1'b0);

    // T4: tiny negative product floors to -1 LSB
    a_vec = 64'h0000_0000_0000_FFFF; d_vec = 32'h0000_0400;
    exp_d = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    kick();
    chk("t4_wrap_data", {16'd0, data1}, 32'h0000_FFFF);
    drain(16, 1'b0, 1'b0);

    // T5: backpressure on (1,0) with ignored starts, then step=0 start in IDLE
    set_t2();
    kick();
    drain(21, 1'b1, 1'b0);
    set_t2();
    step = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_step0_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t5_step0_valid", {31'd0, valid}, 32'd0);

    // T6: async reset while streaming, then a clean run
    set_t2();
    kick();
    tick(); tick();
    chk("t6_pre_col", {31'd0, col}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_valid", {31'd0, valid}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_data", {16'd0, data}, 32'd0);
    chk("t6_row", {30'd0, row}, 32'd0);
    chk("t6_col", {31'd0, col}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    kick();
    drain(16, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
